rtl_kernel_wizard_0_example_axis_gen: RTL and testbench
=======================================================

// Module: rtl_kernel_wizard_0_example_axis_gen
// PURPOSE
//   AXI4-Stream source for the pipelined-adder datapath: emits a packet of ctrl_length beats
//   of deterministic lane data (incrementing 32-bit words from ctrl_seed), honouring tready.
//   Drives the adder's s_axis input in kernel loopback and bring-up; a sink subtracts
//   ctrl_constant back out to check the adder's output.
// PARAMETERS
//   C_AXIS_TDATA_WIDTH  512  stream data width, bits; multiple of C_ADDER_BIT_WIDTH
//   C_ADDER_BIT_WIDTH   32   lane width, bits; LP_NUM_LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH
//   C_LENGTH_WIDTH      32   width of the beat-count register
// PORTS
//   m_axis_aclk     in   1          single clock for the whole block
//   m_axis_aresetn  in   1          asynchronous, active-low reset
//   ctrl_start      in   1          start request, sampled only in IDLE
//   ctrl_length     in   C_LENGTH_WIDTH   packet length in beats, latched on accepted start
//   ctrl_seed       in   C_ADDER_BIT_WIDTH  value of lane 0 in beat 0, latched on accepted start
//   ctrl_busy       out  1          high in RUN and DONE
//   ctrl_done       out  1          1-cycle pulse on packet completion
//   m_axis_tvalid   out  1          AXIS valid
//   m_axis_tready   in   1          AXIS ready
//   m_axis_tdata    out  C_AXIS_TDATA_WIDTH    lane i of beat n = seed + n*LP_NUM_LANES + i
//   m_axis_tkeep    out  C_AXIS_TDATA_WIDTH/8  all ones (see CONFIGURATION)
//   m_axis_tlast    out  1          high on the final beat only
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0,
//     busy=0, done=0, counters 0.
//   - FSM IDLE -> RUN on ctrl_start with ctrl_length != 0. Latch length and seed.
//     tvalid=1 with beat 0 on the next edge, so valid appears 1 cycle after start is sampled.
//   - IDLE -> DONE on ctrl_start with ctrl_length == 0. No beat is emitted; done pulses next cycle.
//   - RUN: beat n is held stable (tdata/tkeep/tlast) while tvalid && !tready. On handshake:
//     if not last, load beat n+1 on the same edge with no bubble (full throughput at tready=1);
//     if last (n == length-1), tvalid=0 and go to DONE.
//   - DONE: done=1 for exactly 1 cycle, then IDLE. busy falls with the IDLE transition.
//   - tvalid never drops without a handshake. Output is driven from registers only.
//   - ctrl_start in RUN/DONE is ignored and not queued. ctrl_length/ctrl_seed changes
//     after latch have no effect.
//   - Lane arithmetic is modulo 2^C_ADDER_BIT_WIDTH; wrap past 0xFFFFFFFF is silent.
//     Next-beat lanes = current lanes + LP_NUM_LANES (per-lane adder, no multiply).
//   - Length 1: single beat with tlast=1. Length 2^C_LENGTH_WIDTH-1 is legal; beat counter
//     does not overflow.
//   - Reset mid-packet: tvalid drops immediately (async); the packet is truncated without
//     tlast, and downstream FIFO reset is the system's responsibility.
// CONFIGURATION
//   AXIS_GEN_PARTIAL_LAST_EN defined: adds input ctrl_last_keep [C_AXIS_TDATA_WIDTH/8-1:0],
//     latched on start and driven on tkeep for the tlast beat only; other beats are all ones.
//     ctrl_last_keep == 0 is treated as all ones. tdata is unaffected by keep.
//   Undefined: port absent; tkeep = all ones on every beat.
// STRUCTURE
//   Shared package cgra_axis_pkg: FSM state encoding (IDLE/RUN/DONE) and the
//     LP_NUM_LANES / byte-count localparam helpers, also reused by the matching checker sink.
//   No sub-module: one FSM, beat counter, and a generate loop of lane incrementers in one file.
// TESTING
//   1 seed=0, length=4, tready=1: 4 back-to-back beats; beat1 lane0=16, beat3 lane15=63;
//     tlast on beat 3; done 1 cycle after final handshake.
//   2 seed=100, length=3, tready toggled 1/0 every cycle: data held stable while stalled;
//     beats carry 100,116,132 in lane0; no beat lost or duplicated.
//   3 length=0 start: tvalid stays 0; done pulses 1 cycle after start; busy high for 1 cycle.
//   4 seed=0xFFFFFFF8, length=1: lane7=0xFFFFFFFF, lane8=0x00000000, lane15=7; tlast=1.
//   5 reset asserted mid-packet at beat 2 of 8: tvalid=0 immediately; a fresh start after
//     release restarts at beat 0 with the new seed.
//   6 ctrl_start pulsed during RUN: ignored, no extra packet; with AXIS_GEN_PARTIAL_LAST_EN,
//     ctrl_last_keep=0x000F gives tkeep=0x000F on the tlast beat and all ones elsewhere.

Source files
------------

// File: rtl/cgra_axis_pkg.sv
// rtl/cgra_axis_pkg.sv - shared FSM encoding and lane/byte sizing helpers for the AXIS generator and checker
package cgra_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } axis_gen_state_t;

  localparam int unsigned LP_BYTE_BITS = 8;

  function automatic int unsigned num_lanes(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  function automatic int unsigned keep_width(input int unsigned data_w);
    return data_w / LP_BYTE_BITS;
  endfunction

endpackage

// File: rtl/rtl_kernel_wizard_0_example_axis_gen.sv
// rtl/rtl_kernel_wizard_0_example_axis_gen.sv - AXIS packet source of incrementing 32-bit lanes
// Optional AXIS_GEN_PARTIAL_LAST_EN adds ctrl_last_keep for the tkeep of the tlast beat.
module rtl_kernel_wizard_0_example_axis_gen
  import cgra_axis_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_LENGTH_WIDTH     = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            ctrl_start,
  input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_seed,
`ifdef AXIS_GEN_PARTIAL_LAST_EN
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] ctrl_last_keep,
`endif
  output logic                            ctrl_busy,
  output logic                            ctrl_done,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int LP_NUM_LANES  = int'(num_lanes(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH));
  localparam int LP_KEEP_WIDTH = int'(keep_width(C_AXIS_TDATA_WIDTH));
  localparam int W             = C_ADDER_BIT_WIDTH;

  axis_gen_state_t             state_q;
  logic [C_LENGTH_WIDTH-1:0]   remaining_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] lanes_init;
  logic [C_AXIS_TDATA_WIDTH-1:0] lanes_next;
  logic [LP_KEEP_WIDTH-1:0]    tkeep_q;
  logic [LP_KEEP_WIDTH-1:0]    start_last_keep;
  logic [LP_KEEP_WIDTH-1:0]    run_last_keep;
  logic                        tvalid_q;
  logic                        tlast_q;
  logic                        busy_q;
  logic                        done_q;

  // Each lane advances by the lane count per beat, so no multiplier is needed.
  for (genvar i = 0; i < LP_NUM_LANES; i++) begin : g_lane
    assign lanes_init[i*W +: W] = ctrl_seed + W'(i);
    assign lanes_next[i*W +: W] = tdata_q[i*W +: W] + W'(LP_NUM_LANES);
  end

`ifdef AXIS_GEN_PARTIAL_LAST_EN
  logic [LP_KEEP_WIDTH-1:0] last_keep_q;

  assign start_last_keep = (ctrl_last_keep == '0) ? '1 : ctrl_last_keep;
  assign run_last_keep   = last_keep_q;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      last_keep_q <= '1;
    end else if (state_q == ST_IDLE && ctrl_start) begin
      last_keep_q <= start_last_keep;
    end
  end
`else
  assign start_last_keep = '1;
  assign run_last_keep   = '1;
`endif

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_start) begin
            busy_q <= 1'b1;
            if (ctrl_length != '0) begin
              state_q     <= ST_RUN;
              remaining_q <= ctrl_length;
              tdata_q     <= lanes_init;
              tvalid_q    <= 1'b1;
              tlast_q     <= (ctrl_length == C_LENGTH_WIDTH'(1));
              tkeep_q     <= (ctrl_length == C_LENGTH_WIDTH'(1)) ? start_last_keep : '1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // remaining_q counts down from length, so length 2^N-1 never overflows.
          if (m_axis_tready) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              remaining_q <= remaining_q - C_LENGTH_WIDTH'(1);
              tdata_q     <= lanes_next;
              tlast_q     <= (remaining_q == C_LENGTH_WIDTH'(2));
              tkeep_q     <= (remaining_q == C_LENGTH_WIDTH'(2)) ? run_last_keep : '1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_rtl_kernel_wizard_0_example_axis_gen.sv
// tb/tb_rtl_kernel_wizard_0_example_axis_gen.sv - directed self-checking bench for the AXIS packet source
module tb_rtl_kernel_wizard_0_example_axis_gen;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int NL = 16;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_start;
  logic [31:0]   ctrl_length;
  logic [31:0]   ctrl_seed;
  logic          ctrl_busy;
  logic          ctrl_done;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
`ifdef AXIS_GEN_PARTIAL_LAST_EN
  logic [KW-1:0] ctrl_last_keep;
`endif

  always #5 clk = ~clk;

  rtl_kernel_wizard_0_example_axis_gen dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .ctrl_start     (ctrl_start),
    .ctrl_length    (ctrl_length),
    .ctrl_seed      (ctrl_seed),
`ifdef AXIS_GEN_PARTIAL_LAST_EN
    .ctrl_last_keep (ctrl_last_keep),
`endif
    .ctrl_busy      (ctrl_busy),
    .ctrl_done      (ctrl_done),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] cap_d[$];
  logic          cap_l[$];
  logic [KW-1:0] cap_k[$];

  typedef struct {
    logic [31:0] seed;
    logic [31:0] len;
    int          mode;
    int          beats;
    logic [31:0] l0_first;
    logic [31:0] l0_last;
    logic [31:0] l15_last;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_model(input logic [31:0] seed, input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*LW +: LW] = seed + 32'(n * NL + i);
    return v;
  endfunction

  // mode 0: tready held high; mode 1: tready toggles 1,0,1,0...
  task automatic run_packet(input logic [31:0] seed, input logic [31:0] len, input int mode,
                            output int done_cnt, output int done_lat, output int busy_cyc);
    int            cyc;
    int            last_hs;
    logic          stalled;
    logic [DW-1:0] held;
    bit            fin;
    cap_d.delete();
    cap_l.delete();
    cap_k.delete();
    ctrl_seed   = seed;
    ctrl_length = len;
    ctrl_start  = 1'b1;
    @(negedge clk);
    ctrl_start  = 1'b0;
    ctrl_seed   = 32'hDEADBEEF;
    ctrl_length = 32'd7;
    chk("valid_after_start", DW'(m_axis_tvalid), DW'(len != 0));
    done_cnt = 0; done_lat = -1; busy_cyc = 0; last_hs = -1;
    stalled = 1'b0; held = '0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 200) begin
      m_axis_tready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (stalled) begin
        chk("stall_hold_data", m_axis_tdata, held);
        chk("stall_hold_valid", DW'(m_axis_tvalid), DW'(1));
      end
      if (ctrl_busy) busy_cyc++;
      if (ctrl_done) begin
        done_cnt++;
        done_lat = cyc - last_hs;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_d.push_back(m_axis_tdata);
        cap_l.push_back(m_axis_tlast);
        cap_k.push_back(m_axis_tkeep);
        last_hs = cyc;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_tdata;
      if (done_cnt > 0 && !ctrl_busy) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL packet_timeout: got busy=%0d after %0d cycles expected packet completion", ctrl_busy, cyc);
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic check_beats(input string tag, input logic [31:0] seed, input logic [KW-1:0] last_keep);
    for (int n = 0; n < cap_d.size(); n++) begin
      chk($sformatf("%s_data%0d", tag, n), cap_d[n], beat_model(seed, n));
      chk($sformatf("%s_tlast%0d", tag, n), DW'(cap_l[n]), DW'(n == cap_d.size() - 1));
      chk($sformatf("%s_tkeep%0d", tag, n), DW'(cap_k[n]),
          (n == cap_d.size() - 1) ? DW'(last_keep) : DW'({KW{1'b1}}));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, dl, bc, hs, dn;
    logic [DW-1:0] b;

    vecs[0] = '{32'd0,          32'd4, 0, 4, 32'd0,          32'd48,         32'd63,         5};
    vecs[1] = '{32'd100,        32'd3, 1, 3, 32'd100,        32'd132,        32'd147,        6};
    vecs[2] = '{32'd5,          32'd0, 0, 0, 32'd0,          32'd0,          32'd0,          1};
    vecs[3] = '{32'hFFFFFFF8,   32'd1, 0, 1, 32'hFFFFFFF8,   32'hFFFFFFF8,   32'd7,          2};
    vecs[4] = '{32'h12345678,   32'd2, 1, 2, 32'h12345678,   32'h12345688,   32'h12345697,   4};

    rst_n = 1'b0; ctrl_start = 1'b0; ctrl_length = '0; ctrl_seed = '0; m_axis_tready = 1'b0;
`ifdef AXIS_GEN_PARTIAL_LAST_EN
    ctrl_last_keep = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
    chk("rst_tdata", m_axis_tdata, DW'(0));
    chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
    chk("rst_busy", DW'(ctrl_busy), DW'(0));
    chk("rst_done", DW'(ctrl_done), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_packet(vecs[v].seed, vecs[v].len, vecs[v].mode, dc, dl, bc);
      chk($sformatf("v%0d_beats", v), DW'(cap_d.size()), DW'(vecs[v].beats));
      chk($sformatf("v%0d_done_cnt", v), DW'(dc), DW'(1));
      chk($sformatf("v%0d_done_lat", v), DW'(dl), DW'(1));
      chk($sformatf("v%0d_busy_cyc", v), DW'(bc), DW'(vecs[v].busy_cyc));
      if (vecs[v].beats > 0 && cap_d.size() == vecs[v].beats) begin
        b = cap_d[0];
        chk($sformatf("v%0d_l0_first", v), DW'(b[31:0]), DW'(vecs[v].l0_first));
        b = cap_d[cap_d.size() - 1];
        chk($sformatf("v%0d_l0_last", v), DW'(b[31:0]), DW'(vecs[v].l0_last));
        chk($sformatf("v%0d_l15_last", v), DW'(b[15*LW +: LW]), DW'(vecs[v].l15_last));
        check_beats($sformatf("v%0d", v), vecs[v].seed, {KW{1'b1}});
      end
      if (v == 3 && cap_d.size() == 1) begin
        b = cap_d[0];
        chk("wrap_lane7", DW'(b[7*LW +: LW]), DW'(32'hFFFFFFFF));
        chk("wrap_lane8", DW'(b[8*LW +: LW]), DW'(32'h00000000));
      end
    end

    // Reset mid-packet at beat 2 of 8, then restart with a fresh seed.
    ctrl_seed = 32'd0; ctrl_length = 32'd8; m_axis_tready = 1'b1; ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    repeat (2) @(negedge clk);
    b = m_axis_tdata;
    chk("midrst_beat2_lane0", DW'(b[31:0]), DW'(32));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("midrst_busy", DW'(ctrl_busy), DW'(0));
    chk("midrst_tlast", DW'(m_axis_tlast), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    run_packet(32'd1000, 32'd2, 0, dc, dl, bc);
    chk("restart_beats", DW'(cap_d.size()), DW'(2));
    chk("restart_done_cnt", DW'(dc), DW'(1));
    check_beats("restart", 32'd1000, {KW{1'b1}});

    // Start pulsed during RUN must be ignored.
    m_axis_tready = 1'b0; ctrl_seed = 32'd0; ctrl_length = 32'd3; ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_start_held_beat0", m_axis_tdata, beat_model(32'd0, 0));
    ctrl_start = 1'b1; ctrl_length = 32'd5; ctrl_seed = 32'd500;
    @(negedge clk);
    ctrl_start = 1'b0;
    m_axis_tready = 1'b1;
    hs = 0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        chk($sformatf("run_start_data%0d", hs), m_axis_tdata, beat_model(32'd0, hs));
        hs++;
      end
      if (ctrl_done) dn++;
      @(negedge clk);
    end
    chk("run_start_beats", DW'(hs), DW'(3));
    chk("run_start_done_cnt", DW'(dn), DW'(1));
    chk("run_start_idle_valid", DW'(m_axis_tvalid), DW'(0));
    m_axis_tready = 1'b0;

`ifdef AXIS_GEN_PARTIAL_LAST_EN
    ctrl_last_keep = 64'h000F;
    run_packet(32'd7, 32'd3, 0, dc, dl, bc);
    ctrl_last_keep = 64'h0;
    chk("pkeep_beats", DW'(cap_d.size()), DW'(3));
    check_beats("pkeep", 32'd7, 64'h000F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
